i2s_transmitter: RTL and testbench

I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

---
 rtl/i2s_transmitter_pkg.sv | 20 ++
 rtl/i2s_transmitter_bclk.sv | 39 +++
 rtl/i2s_transmitter.sv | 98 +++++++++
 tb/tb_i2s_transmitter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/i2s_transmitter_pkg.sv
// Shared audio constants, slot encoding and sample-to-word conversion for the I2S transmitter.
package i2s_transmitter_pkg;

   localparam int unsigned FRAME_BITS  = 32;
   localparam int unsigned WORD_BITS   = 16;
   localparam int unsigned SAMPLE_BITS = 9;
   localparam int unsigned CNT_BITS    = $clog2(FRAME_BITS);
   localparam int unsigned DIV_BITS    = 8;

   typedef enum logic {
      SLOT_LEFT  = 1'b0,
      SLOT_RIGHT = 1'b1
   } slot_e;

   // Offset-binary sample to signed, left-justified slot word (midscale maps to zero).
   function automatic logic [WORD_BITS-1:0] sample_to_word(input logic [SAMPLE_BITS-1:0] s);
      return {~s[SAMPLE_BITS-1], s[SAMPLE_BITS-2:0], {(WORD_BITS-SAMPLE_BITS){1'b0}}};
   endfunction

endpackage

// File: rtl/i2s_transmitter_bclk.sv
// Bit-clock divider: o_bclk toggles every BCLK_DIV cycles; strobes flag the cycle before each edge.
module bclk_generator
   import i2s_transmitter_pkg::*;
#(
   parameter int unsigned BCLK_DIV = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   output logic o_bclk,
   output logic o_rise_stb,
   output logic o_fall_stb
);

   localparam logic [DIV_BITS-1:0] DIV_LAST = DIV_BITS'(BCLK_DIV - 1);

   logic [DIV_BITS-1:0] r_div;
   logic                r_bclk;
   logic                w_tick;

   assign w_tick = (r_div == DIV_LAST);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_div  <= '0;
         r_bclk <= 1'b0;
      end else if (w_tick) begin
         r_div  <= '0;
         r_bclk <= ~r_bclk;
      end else begin
         r_div  <= r_div + DIV_BITS'(1);
      end
   end

   // Strobes are decoded so consumers update on the same edge that moves o_bclk.
   assign o_bclk     = r_bclk;
   assign o_rise_stb = w_tick & ~r_bclk;
   assign o_fall_stb = w_tick &  r_bclk;

endmodule

// File: rtl/i2s_transmitter.sv
// I2S transmitter: one-entry sample holding register, frame word, and MSB-first serialiser.
module i2s_transmitter #(
   parameter int unsigned BCLK_DIV  = 4,
   parameter int unsigned WORD_BITS = 16
) (
   input  logic                                       i_clk,
   input  logic                                       i_rst,
   input  logic [i2s_transmitter_pkg::SAMPLE_BITS-1:0] i_sample,
   input  logic                                       i_sample_valid,
   output logic                                       o_sample_ready,
   output logic                                       o_bclk,
   output logic                                       o_lrclk,
   output logic                                       o_sdata,
   output logic                                       o_underrun
);

   import i2s_transmitter_pkg::*;

   logic                   w_fall_stb;
   logic                   w_unused_rise_stb;
   logic [CNT_BITS-1:0]    w_cnt_next;
   logic [3:0]             w_bit_idx;
   logic                   w_frame_load;
   logic                   w_accept;
   logic                   w_full_next;

   logic [CNT_BITS-1:0]    r_bit_cnt;
   slot_e                  r_lrclk;
   logic                   r_sdata;
   logic [WORD_BITS-1:0]   r_word;
   logic [SAMPLE_BITS-1:0] r_hold;
   logic                   r_full;
   logic                   r_ready;
   logic                   r_underrun;

   bclk_generator #(
      .BCLK_DIV (BCLK_DIV)
   ) u_bclk (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .o_bclk     (o_bclk),
      .o_rise_stb (w_unused_rise_stb),
      .o_fall_stb (w_fall_stb)
   );

   // One-bit I2S delay: new count n carries word bit (16-n) mod 16, so count 0 ends the previous right word.
   assign w_cnt_next   = r_bit_cnt + CNT_BITS'(1);
   assign w_bit_idx    = 4'(CNT_BITS'(WORD_BITS) - w_cnt_next);
   assign w_frame_load = w_fall_stb & (w_cnt_next == '0);
   assign w_accept     = i_sample_valid & r_ready;

   // Frame load empties the holder first; a capture can only happen while it is empty.
   always_comb begin
      w_full_next = r_full;
      if (w_frame_load && r_full) begin
         w_full_next = 1'b0;
      end else if (w_accept) begin
         w_full_next = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_bit_cnt  <= '1;
         r_lrclk    <= SLOT_RIGHT;
         r_sdata    <= 1'b0;
         r_word     <= '0;
         r_hold     <= '0;
         r_full     <= 1'b0;
         r_ready    <= 1'b1;
         r_underrun <= 1'b0;
      end else begin
         if (w_accept) begin
            r_hold <= i_sample;
         end
         if (w_fall_stb) begin
            r_bit_cnt <= w_cnt_next;
            r_lrclk   <= slot_e'(w_cnt_next[CNT_BITS-1]);
            r_sdata   <= r_word[w_bit_idx];
         end
         if (w_frame_load) begin
            if (r_full) begin
               r_word <= sample_to_word(r_hold);
            end else begin
               r_underrun <= 1'b1;
            end
         end
         r_full  <= w_full_next;
         r_ready <= ~w_full_next;
      end
   end

   assign o_sample_ready = r_ready;
   assign o_lrclk        = r_lrclk;
   assign o_sdata        = r_sdata;
   assign o_underrun     = r_underrun;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter: waveform, slot data, handshake, underrun and mid-frame reset.
module tb_i2s_transmitter;

   logic       clk = 1'b0;
   logic       i_rst;
   logic [8:0] i_sample;
   logic       i_sample_valid;
   logic       o_sample_ready;
   logic       o_bclk;
   logic       o_lrclk;
   logic       o_sdata;
   logic       o_underrun;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   i2s_transmitter #(
      .BCLK_DIV  (4),
      .WORD_BITS (16)
   ) dut (
      .i_clk          (clk),
      .i_rst          (i_rst),
      .i_sample       (i_sample),
      .i_sample_valid (i_sample_valid),
      .o_sample_ready (o_sample_ready),
      .o_bclk         (o_bclk),
      .o_lrclk        (o_lrclk),
      .o_sdata        (o_sdata),
      .o_underrun     (o_underrun)
   );

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".bclk"},  16'(o_bclk),         16'h0);
      chk({tag, ".lrclk"}, 16'(o_lrclk),        16'h1);
      chk({tag, ".sdata"}, 16'(o_sdata),        16'h0);
      chk({tag, ".ur"},    16'(o_underrun),     16'h0);
      chk({tag, ".rdy"},   16'(o_sample_ready), 16'h1);
   endtask

   task automatic do_reset(input string tag);
      i_rst          = 1'b1;
      i_sample_valid = 1'b0;
      i_sample       = 9'h000;
      step();
      step();
      chk_reset_outputs(tag);
      i_rst = 1'b0;
      cyc   = 0;
   endtask

   // Runs from cyc 0 (just after the last reset edge) to c_end, checking every cycle.
   // Frame f occupies cycles 8+256f .. 8+256f+255; its word is expected to be w[f].
   task automatic run(input string tag, input int c_end, input int v_from, input int v_to,
                      input logic [8:0] s0, input logic [8:0] s1, input logic [8:0] s2,
                      input logic [15:0] pre, input logic [15:0] w0, input logic [15:0] w1,
                      input logic [15:0] w2, input int ur_from, input int rdy_free);
      logic [15:0] wv [0:2];
      logic [15:0] src;
      int m, n, f;
      logic e_bclk, e_lr, e_sd, e_rdy;
      wv[0] = w0;
      wv[1] = w1;
      wv[2] = w2;
      while (cyc < c_end) begin
         i_sample_valid = (cyc >= v_from) && (cyc <= v_to);
         i_sample       = (cyc < 8) ? s0 : (cyc < 264) ? s1 : s2;
         step();
         e_bclk = 1'((cyc / 4) % 2);
         if (cyc < 8) begin
            e_lr = 1'b1;
            e_sd = 1'b0;
         end else begin
            m    = (cyc - 8) / 8;
            n    = m % 32;
            f    = m / 32;
            e_lr = (n >= 16);
            if (n == 0) begin
               src  = (f == 0) ? pre : wv[f-1];
               e_sd = src[0];
            end else if (n <= 16) begin
               src  = wv[f];
               e_sd = src[16-n];
            end else begin
               src  = wv[f];
               e_sd = src[32-n];
            end
         end
         e_rdy = (cyc >= rdy_free) || ((cyc >= 8) && (((cyc - 8) % 256) == 0));
         chk({tag, ".bclk"},  16'(o_bclk),         16'(e_bclk));
         chk({tag, ".lrclk"}, 16'(o_lrclk),        16'(e_lr));
         chk({tag, ".sdata"}, 16'(o_sdata),        16'(e_sd));
         chk({tag, ".ur"},    16'(o_underrun),     16'(cyc >= ur_from));
         chk({tag, ".rdy"},   16'(o_sample_ready), 16'(e_rdy));
      end
      i_sample_valid = 1'b0;
   endtask

   initial begin
      i_rst          = 1'b1;
      i_sample       = 9'h000;
      i_sample_valid = 1'b0;

      // Full-scale positive sample before frame 0, then starve frame 1.
      do_reset("por");
      run("pos", 530, 0, 0, 9'h1FF, 9'h1FF, 9'h1FF,
          16'h0000, 16'h7F80, 16'h7F80, 16'h7F80, 264, 8);

      // Negative full scale, then midscale, then starve frame 2.
      do_reset("rst2");
      run("negmid", 530, 0, 20, 9'h000, 9'h100, 9'h100,
          16'h0000, 16'h8000, 16'h0000, 16'h0000, 520, 264);

      // Valid held high: one accept per frame load, never an underrun.
      do_reset("rst3");
      run("stream", 780, 0, 100000, 9'h1C0, 9'h0A5, 9'h13C,
          16'h0000, 16'h6000, 16'hD280, 16'h1E00, 100000, 100000);

      // Reset at count 20, then timing must restart exactly as after power-on.
      do_reset("rst4");
      run("pre_abort", 168, 0, 0, 9'h1FF, 9'h1FF, 9'h1FF,
          16'h0000, 16'h7F80, 16'h7F80, 16'h7F80, 264, 8);
      i_rst = 1'b1;
      step();
      chk_reset_outputs("abort");
      i_rst = 1'b0;
      cyc   = 0;
      run("restart", 300, 0, 0, 9'h1FF, 9'h1FF, 9'h1FF,
          16'h0000, 16'h7F80, 16'h7F80, 16'h7F80, 264, 8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
